data_memory_ctrl: RTL

//   Parametrised MIPS data memory with a req/resp handshake.

---
 rtl/data_memory_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressable MIPS data memory behind a req/resp handshake.
// Loads/stores commit at acceptance; the response follows LATENCY edges later.
module data_memory_ctrl #(
    parameter int    ADDR_W    = 18,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-2:0] DEPTH_V = (ADDR_W-1)'(DEPTH);
    localparam logic [1:0] CNT_INIT =
        (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("data_memory_ctrl: LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [31:0] data [0:DEPTH-1];

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic              accept;
    logic [ADDR_W-3:0] widx;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              size_err;
    logic              align_err;
    logic              range_err;
    logic              err_d;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       rdata_d;
    logic              wr_en;

    assign req_ready  = rst_n && (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign widx    = req_addr[ADDR_W-1:2];
    assign idx     = widx[IDX_W-1:0];
    assign rd_word = data[idx];
    assign rd_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{req_addr[1], 4'b0000} +: 16];

    // Classify the request: reserved size, misalignment, out of range
    always_comb begin
        size_err  = (req_size == 2'b11);
        align_err = 1'b0;
        unique case (1'b1)
            (req_size == 2'b01): align_err = req_addr[0];
            (req_size == 2'b10): align_err = (req_addr[1:0] != 2'b00);
            default:             align_err = 1'b0;
        endcase
        range_err = ({1'b0, widx} >= DEPTH_V);
        err_d     = size_err || align_err || range_err;
    end

    // Byte-lane enables and replicated store data for the addressed lanes
    always_comb begin
        be    = 4'b0000;
        wlane = 32'h0;
        unique case (req_size)
            2'b00: begin
                be    = 4'b0001 << req_addr[1:0];
                wlane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wlane = req_wdata;
            end
            default: begin
                be    = 4'b0000;
                wlane = 32'h0;
            end
        endcase
    end

    // Load result with lane extraction and sign/zero extension
    always_comb begin
        rdata_d = 32'h0;
        if (!req_we && !err_d) begin
            unique case (req_size)
                2'b00: rdata_d = req_unsigned ?
                    {24'h0, rd_byte} :
                    {{24{rd_byte[7]}}, rd_byte};
                2'b01: rdata_d = req_unsigned ?
                    {16'h0, rd_half} :
                    {{16{rd_half[15]}}, rd_half};
                2'b10: rdata_d = rd_word;
                default: rdata_d = 32'h0;
            endcase
        end
    end

    assign wr_en = accept && req_we && !err_d;

    // Storage array: stores commit on the acceptance edge, never reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                data[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
